// File: rtl/adder_pkg.sv
// adder_pkg: shared sizing helpers for the pipelined datapath arithmetic blocks.
package adder_pkg;
    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bundle; ovfl exists only with PIPELINED_ADDER_OVFL_EN.
interface pipelined_adder_if #(parameter int WIDTH = 16) ();
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;
    logic             out_ready;
`ifdef PIPELINED_ADDER_OVFL_EN
    logic             ovfl;
    modport master (output in1, in2, cin, in_valid, out_ready, input in_ready, sum, cout, out_valid, ovfl);
    modport slave  (input in1, in2, cin, in_valid, out_ready, output in_ready, sum, cout, out_valid, ovfl);
`else
    modport master (output in1, in2, cin, in_valid, out_ready, input in_ready, sum, cout, out_valid);
    modport slave  (input in1, in2, cin, in_valid, out_ready, output in_ready, sum, cout, out_valid);
`endif
endinterface

// File: rtl/adder_stage.sv
// adder_stage: one CHUNK-bit slice of the pipelined adder, registering its sum, carry and valid.
module adder_stage #(parameter int CHUNK = 4) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    input  logic             v_i,
    input  logic             adv_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             v_o
);
    logic [CHUNK:0] sum_d, sum_q;
    logic           v_q;
    always_comb sum_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            v_q   <= 1'b0;
        end else if (adv_i) begin
            sum_q <= sum_d;
            v_q   <= v_i;
        end
    end
    assign {c_o, s_o} = sum_q;
    assign v_o        = v_q;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add split into STAGES carry-registered chunks with valid/ready backpressure.
// Define PIPELINED_ADDER_OVFL_EN to add the pipelined signed-overflow output.
module pipelined_adder import adder_pkg::*; #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic             clk,
    input logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_bad
        $fatal(1, "pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end
    logic                        adv;
    logic [STAGES:0][WIDTH-1:0]  a_p, b_p;
    logic [STAGES:0]             c_p, v_p;
    logic                        unused_b;
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv & ~rst;
    assign a_p[0]       = bus.in1;
    assign b_p[0]       = bus.in2;
    assign c_p[0]       = bus.cin;
    assign v_p[0]       = bus.in_valid;
    // a_p rotates: each stage drops its consumed operand chunk and pushes its sum chunk in at the top,
    // so after the last stage the word holds the full sum in order.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] s;
        adder_stage #(.CHUNK(CHUNK)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .a_i   (a_p[k][CHUNK-1:0]),
            .b_i   (b_p[k][CHUNK-1:0]),
            .c_i   (c_p[k]),
            .v_i   (v_p[k]),
            .adv_i (adv),
            .s_o   (s),
            .c_o   (c_p[k+1]),
            .v_o   (v_p[k+1])
        );
        if (STAGES == 1) begin : g_one
            assign a_p[k+1] = s;
            assign b_p[k+1] = '0;
        end else begin : g_fwd
            logic [WIDTH-CHUNK-1:0] fa_q, fb_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    fa_q <= '0;
                    fb_q <= '0;
                end else if (adv) begin
                    fa_q <= a_p[k][WIDTH-1:CHUNK];
                    fb_q <= b_p[k][WIDTH-1:CHUNK];
                end
            end
            assign a_p[k+1] = {s, fa_q};
            assign b_p[k+1] = {{CHUNK{1'b0}}, fb_q};
        end
    end
    assign unused_b      = ^b_p[STAGES];
    assign bus.sum       = a_p[STAGES];
    assign bus.cout      = c_p[STAGES];
    assign bus.out_valid = v_p[STAGES];
`ifdef PIPELINED_ADDER_OVFL_EN
    // Carry into the MSB is a^b^sum at the MSB, so only the operand MSB parity needs a flop.
    logic msb_x_q;
    always_ff @(posedge clk) begin
        if (rst) msb_x_q <= 1'b0;
        else if (adv) msb_x_q <= a_p[STAGES-1][CHUNK-1] ^ b_p[STAGES-1][CHUNK-1];
    end
    assign bus.ovfl = msb_x_q ^ bus.sum[WIDTH-1] ^ bus.cout;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder, directed cases plus randomized parameter sweep.
module tb_pipelined_adder;
    localparam int STAGES = 4;
    localparam int SW[4] = '{4, 8, 32, 32};
    localparam int SS[4] = '{1, 2, 32'd8, 32};
    typedef struct packed {
        logic        ov;
        logic [16:0] r;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   sweep_done = 0;
    exp_t q[$];
    always #5 clk = ~clk;
    pipelined_adder_if #(.WIDTH(16)) bus ();
    pipelined_adder #(.WIDTH(16), .STAGES(STAGES)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        int s, ss;
        s  = int'(a) + int'(b) + int'(c);
        ss = int'($signed(a)) + int'($signed(b)) + int'(c);
        model.r  = 17'(s);
        model.ov = (ss > 32767) || (ss < -32768);
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (q.size() == 0) check("spurious_out", 64'(bus.out_valid), 0);
            else begin
                e = q.pop_front();
                check("sum_cout", 64'({bus.cout, bus.sum}), 64'(e.r));
`ifdef PIPELINED_ADDER_OVFL_EN
                check("ovfl", 64'(bus.ovfl), 64'(e.ov));
`endif
            end
        end
        if (rst) q.delete();
        else if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in1, bus.in2, bus.cin));
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
        bus.in_valid = v;
        bus.in1      = a;
        bus.in2      = b;
        bus.cin      = c;
    endtask
    logic [15:0] a_tab[17] = '{16'h0006, 16'hFFFF, 16'h0000, 16'h0001, 16'h000F, 16'h0008, 16'h0007, 16'h0003, 16'h000A,
                               16'h0005, 16'h0009, 16'h000C, 16'h0002, 16'h000E, 16'h0004, 16'h000B, 16'h0000};
    logic [15:0] b_tab[17] = '{16'h000D, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h0008, 16'h0009, 16'h0004, 16'h0005,
                               16'h000A, 16'h0007, 16'h0003, 16'h000E, 16'h0002, 16'h000C, 16'h0004, 16'hFFFF};
    logic        c_tab[17] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
    initial begin
        int   n0;
        logic any_v, ok_rdy;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h0001, 1'b0);
        step();
        step();
        check("in_ready_in_rst", 64'(bus.in_ready), 0);
        check("reset_outputs", 64'({bus.out_valid, bus.cout, bus.sum}), 0);
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        any_v = 1'b0;
        repeat (5) begin
            step();
            any_v |= bus.out_valid;
        end
        check("reset_wins", 64'(any_v), 0);
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        any_v = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            any_v |= bus.out_valid;
            step();
        end
        check("ripple_early", 64'(any_v), 0);
        check("ripple_result", 64'({bus.out_valid, bus.cout, bus.sum}), 64'({1'b1, 1'b1, 16'h0000}));
        step();
        check("ripple_after", 64'(bus.out_valid), 0);
        n0 = n_out;
        ok_rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, a_tab[i], b_tab[i], c_tab[i]);
            ok_rdy &= bus.in_ready;
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        repeat (STAGES) step();
        check("stream_count", 64'(n_out - n0), 17);
        check("stream_in_ready", 64'(ok_rdy), 1);
        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        step();
        drive(1'b1, 16'h0001, 16'h0002, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", 64'({bus.out_valid, bus.cout, bus.sum}), 64'({1'b1, 1'b0, 16'h2345}));
            check("bp_in_ready", 64'(bus.in_ready), 0);
            if (i < 2) step();
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_second", 64'({bus.out_valid, bus.cout, bus.sum}), 64'({1'b1, 1'b0, 16'h0003}));
        step();
        check("bp_empty", 64'(bus.out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(100 * i + 7), 16'(i + 1), 1'b1);
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        step();
        check("midflight_rst", 64'({bus.out_valid, bus.cout, bus.sum}), 0);
        rst = 1'b0;
        any_v = 1'b0;
        repeat (4) begin
            step();
            any_v |= bus.out_valid;
        end
        check("no_stale", 64'(any_v), 0);
`ifdef PIPELINED_ADDER_OVFL_EN
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        step();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        repeat (STAGES + 1) step();
`endif
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 1'($urandom));
            bus.out_ready = $urandom_range(0, 9) < 7;
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        check("drain_main", 64'(q.size()), 0);
        for (int i = 0; i < 20000 && sweep_done < 4; i++) step();
        check("sweep_done", 64'(sweep_done), 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = SW[g];
        localparam int S = SS[g];
        logic srst;
        logic [W:0] sq[$];
        pipelined_adder_if #(.WIDTH(W)) sb ();
        pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(srst), .bus(sb));
        always @(negedge clk) begin
            if (sb.out_valid && sb.out_ready) begin
                if (sq.size() == 0) check("sweep_spurious", 64'(sb.out_valid), 0);
                else check($sformatf("sweep_%0d_%0d", W, S), 64'({sb.cout, sb.sum}), 64'(sq.pop_front()));
            end
            if (!srst && sb.in_valid && sb.in_ready)
                sq.push_back((W+1)'(longint'(sb.in1) + longint'(sb.in2) + longint'(sb.cin)));
        end
        initial begin
            srst = 1'b1;
            sb.in_valid = 1'b0;
            sb.in1 = '0;
            sb.in2 = '0;
            sb.cin = 1'b0;
            sb.out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1 srst = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                sb.in_valid = $urandom_range(0, 3) != 0;
                sb.in1 = W'($urandom);
                sb.in2 = W'($urandom);
                sb.cin = 1'($urandom);
                if ($urandom_range(0, 7) == 0) sb.in1 = '1;
                sb.out_ready = $urandom_range(0, 3) != 0;
                @(posedge clk);
                #1;
            end
            sb.in_valid = 1'b0;
            sb.out_ready = 1'b1;
            for (int i = 0; i < 100 && sq.size() != 0; i++) begin
                @(posedge clk);
                #1;
            end
            check("sweep_drain", 64'(sq.size()), 0);
            sweep_done++;
        end
    end
endmodule
